// File: rtl/mem_burst_master_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_burst_master_pkg
// Description : Shared definitions for the exmem burst master: memory
//               geometry, byte-lane index width and the controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_burst_master_pkg;

  localparam int MEM_DEPTH = 256;
  localparam int MAX_BYTES = 4;
  localparam int LANE_BITS = $clog2(MAX_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_rd_assemble.sv
`default_nettype none
// ============================================================================
// Module      : mem_rd_assemble
// Description : Byte-lane capture register. Collects read bytes into a
//               little-endian word, one lane per write enable.
// Ports       : clk, reset (async, active-high)
//               clr_i   - zero the whole word (wins over we_i)
//               we_i    - write din_i into lane idx_i
//               idx_i   - lane index
//               din_i   - byte to capture
//               dout_o  - assembled word
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rd_assemble #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [$clog2(LANES)-1:0]   idx_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [LANES*WIDTH-1:0]     dout_o
);

  localparam int IDX_BITS = $clog2(LANES);

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [WIDTH-1:0] lane_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          lane_q <= '0;
        end else if (clr_i) begin
          lane_q <= '0;
        end else if (we_i && (idx_i == IDX_BITS'(l))) begin
          lane_q <= din_i;
        end
      end

      assign dout_o[l*WIDTH +: WIDTH] = lane_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_master
// Description : Processor-side initiator for the negedge-clocked exmem byte
//               RAM. Accepts a 1..MAX_BYTES command, issues one byte access
//               per cycle and returns read bytes as a little-endian word.
// Ports       : clk, reset (async, active-high)
//               cmd_valid/cmd_ready/cmd_write/cmd_adr/cmd_len/cmd_wdata
//               resp_valid/resp_ready/resp_rdata/resp_err
//               mem_en/mem_memwrite/mem_adr/mem_writedata (registered), mem_memdata
// Config      : MEM_BURST_ADR_CHECK_EN - reject bursts that run past the top
//               address with resp_err instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_master
  import mem_burst_master_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 8,
  parameter int MAX_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_BITS-1:0]          cmd_adr,
  input  logic [$clog2(MAX_BYTES)-1:0]  cmd_len,
  input  logic [MAX_BYTES*WIDTH-1:0]    cmd_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [MAX_BYTES*WIDTH-1:0]    resp_rdata,
  output logic                          resp_err,
  output logic                          mem_en,
  output logic                          mem_memwrite,
  output logic [ADDR_BITS-1:0]          mem_adr,
  output logic [WIDTH-1:0]              mem_writedata,
  input  logic [WIDTH-1:0]              mem_memdata
);

  localparam int LEN_BITS  = $clog2(MAX_BYTES);
  localparam int DATA_BITS = MAX_BYTES * WIDTH;

`ifdef MEM_BURST_ADR_CHECK_EN
  localparam bit ADR_CHECK_EN = 1'b1;
`else
  localparam bit ADR_CHECK_EN = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [LEN_BITS-1:0]    cnt_q, cnt_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic [DATA_BITS-1:0]   wdata_q, wdata_d;
  logic                   en_q, en_d;
  logic                   we_q, we_d;
  logic [ADDR_BITS-1:0]   adr_q, adr_d;
  logic [WIDTH-1:0]       wd_q, wd_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   rd_clr;
  logic                   rd_cap;

  logic [LEN_BITS-1:0]    cnt_nxt;
  logic [ADDR_BITS:0]     burst_end;
  logic                   burst_ovf;

  assign cnt_nxt   = cnt_q + LEN_BITS'(1);
  // One extra bit catches a burst whose last byte lies past the top address.
  assign burst_end = {1'b0, cmd_adr} + (ADDR_BITS+1)'(cmd_len);
  assign burst_ovf = ADR_CHECK_EN && burst_end[ADDR_BITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wd_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    en_d    = en_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    rd_clr  = 1'b0;
    rd_cap  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rd_clr  = 1'b1;
          len_d   = cmd_len;
          wdata_d = cmd_wdata;
          cnt_d   = '0;
          adr_d   = cmd_adr;
          wd_d    = cmd_wdata[WIDTH-1:0];
          err_d   = 1'b0;
          ovf_d   = burst_ovf;
          // A rejected burst never touches memory.
          en_d    = !burst_ovf;
          we_d    = cmd_write && !burst_ovf;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // The byte issued last cycle is on mem_memdata now; capture it while
        // the next byte goes out.
        rd_cap = en_q && !we_q;
        if (ovf_q || (cnt_q == len_q)) begin
          en_d    = 1'b0;
          we_d    = 1'b0;
          valid_d = 1'b1;
          err_d   = ovf_q;
          ovf_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_nxt;
          adr_d = adr_q + ADDR_BITS'(1);
          wd_d  = wdata_q[cnt_nxt*WIDTH +: WIDTH];
        end
      end

      S_RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  mem_rd_assemble #(
    .WIDTH (WIDTH),
    .LANES (MAX_BYTES)
  ) u_rd_assemble (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (rd_clr),
    .we_i   (rd_cap),
    .idx_i  (cnt_q),
    .din_i  (mem_memdata),
    .dout_o (resp_rdata)
  );

  assign cmd_ready     = (state_q == S_IDLE);
  assign resp_valid    = valid_q;
  assign resp_err      = err_q;
  assign mem_en        = en_q;
  assign mem_memwrite  = we_q;
  assign mem_adr       = adr_q;
  assign mem_writedata = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_burst_master
// Description : Self-checking bench for mem_burst_master with a negedge
//               byte RAM and a command-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_burst_master;

`ifdef MEM_BURST_ADR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_adr;
  logic [1:0]  cmd_len;
  logic [31:0] cmd_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_en, mem_memwrite;
  logic [7:0]  mem_adr, mem_writedata;
  logic [7:0]  mem_memdata = 8'h00;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  bit         init_done = 1'b0;
  logic [7:0] adr_log [$];

  mem_burst_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_memwrite(mem_memwrite), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    case (a)
      8'h05:   return 8'hA5;
      8'h10:   return 8'h11;
      8'h11:   return 8'h22;
      8'h12:   return 8'h33;
      8'h13:   return 8'h44;
      default: return 8'((a * 37 + 11) & 255);
    endcase
  endfunction

  // Byte RAM acting on the falling edge, like exmem.
  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_memwrite) mem[mem_adr] <= mem_writedata;
      mem_memdata <= mem[mem_adr];
    end
  end

  always @(negedge clk) if (mem_en) adr_log.push_back(mem_adr);

  // Command-level reference: what a whole command must do to memory/response.
  task automatic model_cmd(input logic wr, input logic [7:0] adr, input logic [1:0] len,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    int a;
    rd = 32'h0;
    if (CHECK_EN && (int'(adr) + int'(len) > 255)) begin
      er = 1'b1; lat = 1;
    end else begin
      er = 1'b0; lat = int'(len) + 1;
      for (int i = 0; i <= int'(len); i++) begin
        a = (int'(adr) + i) % 256;
        if (wr) ref_mem[a] = wd[8*i +: 8];
        else    rd[8*i +: 8] = ref_mem[a];
      end
    end
  endtask

  // Drive one command and wait for its response; leaves resp_ready untouched.
  task automatic run_cmd(input logic wr, input logic [7:0] adr, input logic [1:0] len,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output bit tmo);
    int n;
    tmo = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_adr = adr; cmd_len = len; cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) tmo = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) tmo = 1'b1;
    rd = resp_rdata;
    er = resp_err;
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err); else passed++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", resp_rdata); else passed++;
    checks++; if ({mem_en, mem_memwrite, mem_adr, mem_writedata} !== 18'h0)
      $display("FAIL reset_mem_outs: got %h want 0", {mem_en, mem_memwrite, mem_adr, mem_writedata}); else passed++;
  endtask

  task automatic test_read4();
    int lat, elat; logic [31:0] rd, erd; logic er, eer; bit tmo;
    model_cmd(1'b0, 8'h10, 2'd3, 32'h0, erd, eer, elat);
    run_cmd(1'b0, 8'h10, 2'd3, 32'h0, lat, rd, er, tmo);
    checks++; if (tmo || lat !== 4) $display("FAIL read4_latency: got %0d (timeout %0d) want 4", lat, tmo); else passed++;
    checks++; if (rd !== 32'h44332211) $display("FAIL read4_rdata: got %h want 44332211", rd); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL read4_err: got %b want 0", er); else passed++;
    retire();
  endtask

  task automatic test_write_read();
    int lat, elat; logic [31:0] rd, erd; logic er, eer; bit tmo;
    model_cmd(1'b1, 8'h20, 2'd1, 32'h0000BEEF, erd, eer, elat);
    run_cmd(1'b1, 8'h20, 2'd1, 32'h0000BEEF, lat, rd, er, tmo);
    checks++; if (tmo || lat !== 2) $display("FAIL write_latency: got %0d (timeout %0d) want 2", lat, tmo); else passed++;
    checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL write_resp: got %h/%b want 0/0", rd, er); else passed++;
    retire();
    checks++; if (mem[8'h20] !== 8'hEF || mem[8'h21] !== 8'hBE)
      $display("FAIL write_mem: got %h%h want BEEF", mem[8'h21], mem[8'h20]); else passed++;
    model_cmd(1'b0, 8'h20, 2'd1, 32'h0, erd, eer, elat);
    run_cmd(1'b0, 8'h20, 2'd1, 32'h0, lat, rd, er, tmo);
    checks++; if (tmo || rd !== 32'h0000BEEF) $display("FAIL readback: got %h want 0000BEEF", rd); else passed++;
    retire();
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd; logic er; bit tmo;
    run_cmd(1'b0, 8'h05, 2'd0, 32'h0, lat, rd, er, tmo);
    checks++; if (tmo || lat !== 1) $display("FAIL hold_latency: got %0d want 1", lat); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000A5 || cmd_ready !== 1'b0)
        $display("FAIL hold_stable[%0d]: got v=%b d=%h rdy=%b want 1/000000a5/0", c, resp_valid, resp_rdata, cmd_ready);
      else passed++;
    end
    retire();
    checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL hold_retire: got v=%b rdy=%b want 0/1", resp_valid, cmd_ready); else passed++;
  endtask

  task automatic test_wrap();
    int lat, elat, start; logic [31:0] rd, erd; logic er, eer; bit tmo;
    start = adr_log.size();
    model_cmd(1'b0, 8'hFE, 2'd2, 32'h0, erd, eer, elat);
    run_cmd(1'b0, 8'hFE, 2'd2, 32'h0, lat, rd, er, tmo);
    retire();
    checks++; if (tmo || lat !== elat) $display("FAIL wrap_latency: got %0d want %0d", lat, elat); else passed++;
    checks++; if (rd !== erd || er !== eer) $display("FAIL wrap_resp: got %h/%b want %h/%b", rd, er, erd, eer); else passed++;
    checks++;
    if (CHECK_EN) begin
      if (adr_log.size() != start) $display("FAIL wrap_no_access: got %0d accesses want 0", adr_log.size() - start);
      else passed++;
    end else begin
      if (adr_log.size() != start + 3 || adr_log[start] !== 8'hFE || adr_log[start+1] !== 8'hFF || adr_log[start+2] !== 8'h00)
        $display("FAIL wrap_adr_seq: got %0d accesses want FE,FF,00", adr_log.size() - start);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    wd = $urandom;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_adr = 8'h40; cmd_len = 2'd3; cmd_wdata = wd;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_idle: got rdy=%b want 1", cmd_ready); else passed++;
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (mem_en !== 1'b1 || mem_adr !== 8'h42)
      $display("FAIL rstmid_byte2: got en=%b adr=%h want 1/42", mem_en, mem_adr); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (mem_en !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rstmid_async: got en=%b v=%b want 0/0", mem_en, resp_valid); else passed++;
    ref_mem[8'h40] = wd[7:0];
    ref_mem[8'h41] = wd[15:8];
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", cmd_ready); else passed++;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0 || mem_en !== 1'b0)
        $display("FAIL rstmid_quiet[%0d]: got v=%b en=%b want 0/0", c, resp_valid, mem_en); else passed++;
    end
    checks++; if (mem[8'h42] !== init_val(8'h42) || mem[8'h43] !== init_val(8'h43))
      $display("FAIL rstmid_mem_hi: got %h %h want %h %h", mem[8'h42], mem[8'h43], init_val(8'h42), init_val(8'h43));
    else passed++;
    checks++; if (mem[8'h40] !== wd[7:0] || mem[8'h41] !== wd[15:8])
      $display("FAIL rstmid_mem_lo: got %h %h want %h %h", mem[8'h40], mem[8'h41], wd[7:0], wd[15:8]);
    else passed++;
  endtask

  task automatic test_random();
    int lat, elat, bad; logic [31:0] rd, erd, wd; logic er, eer, wr; logic [7:0] adr; logic [1:0] len; bit tmo;
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom); adr = 8'($urandom); len = 2'($urandom); wd = $urandom;
      model_cmd(wr, adr, len, wd, erd, eer, elat);
      run_cmd(wr, adr, len, wd, lat, rd, er, tmo);
      checks++;
      if (tmo || lat !== elat || rd !== erd || er !== eer)
        $display("FAIL rand[%0d] wr=%b adr=%h len=%0d: got lat=%0d d=%h e=%b want lat=%0d d=%h e=%b",
                 k, wr, adr, len, lat, rd, er, elat, erd, eer);
      else passed++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      retire();
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) $display("FAIL rand_mem_image: got %0d differing bytes want 0", bad); else passed++;
  endtask

  task automatic test_back_to_back();
    int n, lat, elat; logic [31:0] erd; logic eer; bit tmo;
    resp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_adr = 8'($urandom_range(0, 200)); cmd_len = 2'($urandom);
    cmd_wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      model_cmd(1'b0, cmd_adr, cmd_len, 32'h0, erd, eer, elat);
      if (k == 3) cmd_valid = 1'b0;
      else begin cmd_adr = 8'($urandom_range(0, 200)); cmd_len = 2'($urandom); end
      lat = 0;
      while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      tmo = (n >= 20) || !resp_valid;
      checks++;
      if (tmo || lat !== elat || resp_rdata !== erd)
        $display("FAIL b2b[%0d]: got lat=%0d d=%h want lat=%0d d=%h", k, lat, resp_rdata, elat, erd);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0 || cmd_ready !== 1'b1)
        $display("FAIL b2b_gap[%0d]: got v=%b rdy=%b want 0/1", k, resp_valid, cmd_ready);
      else passed++;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0 || cmd_ready !== 1'b1)
      $display("FAIL b2b_extra: got v=%b rdy=%b want 0/1", resp_valid, cmd_ready); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_wdata = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_read4();
    test_write_read();
    test_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
